cache_arbiter: RTL and testbench

- Sits between the instruction cache, the data cache and physical memory.
- Grants one cache-line transaction at a time to either cache.
- Converts the granted 256-bit line transfer into a four-beat 64-bit burst on the memory port.
- Returns the completed line, or a write acknowledge, to the requesting cache with a one-cycle response pulse.

---
 rtl/cache_arb_pkg.sv | 28 ++
 rtl/cache_arbiter_if.sv | 47 ++++
 rtl/cache_arbiter_adaptor.sv | 91 +++++++++
 rtl/cache_arbiter.sv | 72 +++++++
 tb/tb_cache_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache arbiter slice.
// Line/burst geometry, FSM states, owner encoding, address align helper.
package cache_arb_pkg;

  localparam int LINE_BITS   = 256;
  localparam int BURST_BITS  = 64;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  function automatic logic [31:0] line_align(
    input logic [31:0] a
  );
    return a & ~((32'd1 << OFFSET_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory port signals of the arbiter.
// slave: arbiter view; master: view of the caches/memory around it.
interface cache_arbiter_if;
  import cache_arb_pkg::*;

  logic [31:0]           i_pmem_address;
  logic                  i_pmem_read;
  logic [LINE_BITS-1:0]  i_pmem_rdata;
  logic                  i_pmem_resp;

  logic [31:0]           d_pmem_address;
  logic [LINE_BITS-1:0]  d_pmem_wdata;
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [LINE_BITS-1:0]  d_pmem_rdata;
  logic                  d_pmem_resp;

  logic [31:0]           mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [BURST_BITS-1:0] mem_burst_o;
  logic [BURST_BITS-1:0] mem_burst_i;
  logic                  mem_resp;

  modport slave (
    input  i_pmem_address, i_pmem_read,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_address, d_pmem_wdata,
    input  d_pmem_read, d_pmem_write,
    output d_pmem_rdata, d_pmem_resp,
    output mem_address, mem_read, mem_write,
    output mem_burst_o,
    input  mem_burst_i, mem_resp
  );

  modport master (
    output i_pmem_address, i_pmem_read,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_address, d_pmem_wdata,
    output d_pmem_read, d_pmem_write,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_address, mem_read, mem_write,
    input  mem_burst_o,
    output mem_burst_i, mem_resp
  );

endinterface

// File: rtl/cache_arbiter_adaptor.sv
// Line buffer, beat counter and four-beat burst FSM toward memory.
// Ports: start_rd/start_wr + addr/wdata in, line/done/idle + mem bus out.
module cacheline_adaptor
  import cache_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_rd,
  input  logic                  start_wr,
  input  logic [31:0]           addr,
  input  logic [LINE_BITS-1:0]  wdata,
  input  logic [BURST_BITS-1:0] mem_burst_i,
  input  logic                  mem_resp,
  output logic [LINE_BITS-1:0]  line,
  output logic                  done,
  output logic                  idle,
  output logic [31:0]           mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BURST_BITS-1:0] mem_burst_o
);

  localparam logic [1:0] LAST = 2'(BEATS - 1);

  arb_state_t           state;
  logic [1:0]           cnt;
  logic [LINE_BITS-1:0] line_buf;

  assign line        = line_buf;
  assign idle        = (state == IDLE);
  assign mem_burst_o = line_buf[{cnt, 6'd0} +: BURST_BITS];

  // Counter increments on the last beat too, so it returns to 0
  // exactly as the FSM enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      line_buf    <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_wr) begin
            state       <= WRITE;
            mem_write   <= 1'b1;
            line_buf    <= wdata;
            mem_address <= line_align(addr);
            cnt         <= '0;
          end else if (start_rd) begin
            state       <= READ;
            mem_read    <= 1'b1;
            mem_address <= line_align(addr);
            cnt         <= '0;
          end
        end
        READ: begin
          if (mem_resp) begin
            line_buf[{cnt, 6'd0} +: BURST_BITS] <= mem_burst_i;
            cnt <= cnt + 2'd1;
            if (cnt == LAST) begin
              state    <= DONE;
              mem_read <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_resp) begin
            cnt <= cnt + 2'd1;
            if (cnt == LAST) begin
              state     <= DONE;
              mem_write <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one memory port.
// Ports: clk, rst (sync, active-high), bus (cache_arbiter_if.slave).
module cache_arbiter
  import cache_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  logic                 i_req;
  logic                 d_req;
  logic                 d_wr;
  logic                 grant_i;
  logic                 grant_d;
  logic                 idle;
  logic                 done;
  logic [31:0]          req_addr;
  logic [LINE_BITS-1:0] line;
  owner_t               owner;
  owner_t               last_grant;

  assign i_req = bus.i_pmem_read;
  assign d_wr  = bus.d_pmem_write;
  assign d_req = bus.d_pmem_read | d_wr;

  // On a tie the cache that did not win last time goes first.
  assign grant_i = idle & i_req
                 & (~d_req | (last_grant == OWN_D));
  assign grant_d = idle & d_req & ~grant_i;

  assign req_addr = grant_d ? bus.d_pmem_address
                            : bus.i_pmem_address;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_I;
      last_grant <= OWN_D;
    end else begin
      if (grant_i)
        owner <= OWN_I;
      else if (grant_d)
        owner <= OWN_D;
      if (done)
        last_grant <= owner;
    end
  end

  cacheline_adaptor u_adaptor (
    .clk         (clk),
    .rst         (rst),
    .start_rd    (grant_i | (grant_d & ~d_wr)),
    .start_wr    (grant_d & d_wr),
    .addr        (req_addr),
    .wdata       (bus.d_pmem_wdata),
    .mem_burst_i (bus.mem_burst_i),
    .mem_resp    (bus.mem_resp),
    .line        (line),
    .done        (done),
    .idle        (idle),
    .mem_address (bus.mem_address),
    .mem_read    (bus.mem_read),
    .mem_write   (bus.mem_write),
    .mem_burst_o (bus.mem_burst_o)
  );

  assign bus.i_pmem_rdata = line;
  assign bus.d_pmem_rdata = line;
  assign bus.i_pmem_resp  = done & (owner == OWN_I);
  assign bus.d_pmem_resp  = done & (owner == OWN_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
// Drives caches and a memory beat source through the interface.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cache_arbiter_if bus();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] L1 = {
    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L2 = {
    64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
    64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
  localparam logic [255:0] L3 = {
    64'hB3B3_B3B3_0000_1111, 64'hB2B2_B2B2_0000_2222,
    64'hB1B1_B1B1_0000_3333, 64'hB0B0_B0B0_0000_4444};
  localparam logic [255:0] L4 = {
    64'hC0DE_0003_C0DE_0003, 64'hC0DE_0002_C0DE_0002,
    64'hC0DE_0001_C0DE_0001, 64'hC0DE_0000_C0DE_0000};
  localparam logic [255:0] L5 = {
    64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
    64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
  localparam logic [255:0] L6 = {
    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
    64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
  localparam logic [255:0] L7 = {
    64'h7777_0000_7777_0003, 64'h7777_0000_7777_0002,
    64'h7777_0000_7777_0001, 64'h7777_0000_7777_0000};
  localparam logic [255:0] W = {
    32'd7, 32'd6, 32'd5, 32'd4,
    32'd3, 32'd2, 32'd1, 32'd0};

  task automatic chk(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serves four beats; "first" idle cycles before beat 0,
  // "gap" idle cycles before each later beat.
  task automatic beats(
    input string        tag,
    input int           first,
    input int           gap,
    input logic [31:0]  addr,
    input logic [255:0] rline,
    input logic [255:0] wline,
    input bit           wr
  );
    for (int k = 0; k < 4; k++) begin
      repeat (k == 0 ? first : gap) begin
        bus.mem_resp = 1'b0;
        tick();
      end
      bus.mem_resp    = 1'b1;
      bus.mem_burst_i = rline[k*64 +: 64];
      chk({tag, "_busy"},
          wr ? bus.mem_write : bus.mem_read, 256'd1);
      chk({tag, "_addr"}, bus.mem_address, addr);
      if (wr)
        chk({tag, "_wbeat"}, bus.mem_burst_o,
            wline[k*64 +: 64]);
      chk({tag, "_noresp"},
          {bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
      tick();
    end
    bus.mem_resp = 1'b0;
  endtask

  initial begin
    bus.i_pmem_address = '0;
    bus.i_pmem_read    = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.mem_burst_i    = '0;
    bus.mem_resp       = 1'b0;

    repeat (3) tick();
    chk("rst_mem_read",  bus.mem_read, 256'd0);
    chk("rst_mem_write", bus.mem_write, 256'd0);
    chk("rst_resp",
        {bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    chk("rst_addr",   bus.mem_address, 256'd0);
    chk("rst_burst_o", bus.mem_burst_o, 256'd0);
    chk("rst_line",   bus.i_pmem_rdata, 256'd0);
    rst = 1'b0;

    // I read alone, minimum latency
    bus.i_pmem_address = 32'h0000_1234;
    bus.i_pmem_read    = 1'b1;
    tick();
    chk("iread_req", bus.mem_read, 256'd1);
    chk("iread_wr0", bus.mem_write, 256'd0);
    beats("iread", 1, 0, 32'h0000_1220, L1, '0, 1'b0);
    chk("iread_resp", bus.i_pmem_resp, 256'd1);
    chk("iread_dresp", bus.d_pmem_resp, 256'd0);
    chk("iread_data", bus.i_pmem_rdata, L1);
    chk("iread_rd_low", bus.mem_read, 256'd0);
    bus.i_pmem_read = 1'b0;
    tick();
    chk("iread_pulse", bus.i_pmem_resp, 256'd0);

    // D write with one-cycle gaps between beats
    bus.d_pmem_address = 32'h8000_00E0;
    bus.d_pmem_wdata   = W;
    bus.d_pmem_write   = 1'b1;
    tick();
    chk("dwr_req", bus.mem_write, 256'd1);
    beats("dwr", 1, 1, 32'h8000_00E0, '0, W, 1'b1);
    chk("dwr_resp", bus.d_pmem_resp, 256'd1);
    chk("dwr_iresp", bus.i_pmem_resp, 256'd0);
    chk("dwr_wr_low", bus.mem_write, 256'd0);
    bus.d_pmem_write = 1'b0;
    tick();
    chk("dwr_pulse", bus.d_pmem_resp, 256'd0);

    // Ties out of reset: I first, then D, then I
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_pmem_address = 32'h0000_0100;
    bus.d_pmem_address = 32'h0000_0200;
    bus.i_pmem_read    = 1'b1;
    bus.d_pmem_read    = 1'b1;
    tick();
    beats("tie1", 1, 0, 32'h0000_0100, L2, '0, 1'b0);
    chk("tie1_iresp", bus.i_pmem_resp, 256'd1);
    chk("tie1_dresp", bus.d_pmem_resp, 256'd0);
    chk("tie1_data", bus.i_pmem_rdata, L2);
    bus.i_pmem_address = 32'h0000_0300;
    tick();
    chk("tie2_idle", bus.mem_read, 256'd0);
    chk("tie2_noresp",
        {bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    tick();
    beats("tie2", 0, 0, 32'h0000_0200, L3, '0, 1'b0);
    chk("tie2_dresp", bus.d_pmem_resp, 256'd1);
    chk("tie2_iresp", bus.i_pmem_resp, 256'd0);
    chk("tie2_data", bus.d_pmem_rdata, L3);
    bus.d_pmem_read = 1'b0;
    tick();
    tick();
    beats("tie3", 0, 0, 32'h0000_0300, L4, '0, 1'b0);
    chk("tie3_iresp", bus.i_pmem_resp, 256'd1);
    chk("tie3_data", bus.i_pmem_rdata, L4);
    bus.i_pmem_read = 1'b0;
    tick();

    // Reset after beat 1, then a tie: I must win again
    bus.i_pmem_address = 32'h0000_0600;
    bus.i_pmem_read    = 1'b1;
    tick();
    tick();
    bus.mem_resp    = 1'b1;
    bus.mem_burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus.mem_burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
    tick();
    bus.mem_resp = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_rd_low", bus.mem_read, 256'd0);
    chk("mrst_noresp",
        {bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    chk("mrst_line", bus.i_pmem_rdata, 256'd0);
    rst = 1'b0;
    bus.i_pmem_address = 32'h0000_0700;
    bus.d_pmem_address = 32'h0000_0780;
    bus.d_pmem_read    = 1'b1;
    tick();
    beats("mrst_i", 0, 0, 32'h0000_0700, L6, '0, 1'b0);
    chk("mrst_iresp", bus.i_pmem_resp, 256'd1);
    chk("mrst_data", bus.i_pmem_rdata, L6);
    bus.i_pmem_read = 1'b0;
    tick();
    tick();
    beats("mrst_d", 0, 0, 32'h0000_0780, L7, '0, 1'b0);
    chk("mrst_dresp", bus.d_pmem_resp, 256'd1);
    bus.d_pmem_read = 1'b0;
    tick();

    // D raised during an I burst
    bus.i_pmem_address = 32'h0000_0400;
    bus.i_pmem_read    = 1'b1;
    tick();
    bus.d_pmem_address = 32'h0000_0500;
    bus.d_pmem_read    = 1'b1;
    beats("late_i", 1, 0, 32'h0000_0400, L4, '0, 1'b0);
    chk("late_iresp", bus.i_pmem_resp, 256'd1);
    chk("late_dwait", bus.d_pmem_resp, 256'd0);
    bus.i_pmem_read = 1'b0;
    tick();
    chk("late_hold", bus.mem_address, 256'h400);
    chk("late_dwait2", bus.d_pmem_resp, 256'd0);
    tick();
    beats("late_d", 2, 1, 32'h0000_0500, L5, '0, 1'b0);
    chk("late_dresp", bus.d_pmem_resp, 256'd1);
    chk("late_data", bus.d_pmem_rdata, L5);
    bus.d_pmem_read = 1'b0;
    tick();

    // Spurious mem_resp in IDLE
    tick();
    bus.mem_resp    = 1'b1;
    bus.mem_burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    chk("spur_rd", bus.mem_read, 256'd0);
    chk("spur_wr", bus.mem_write, 256'd0);
    chk("spur_resp",
        {bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    chk("spur_cnt", bus.mem_burst_o, L5[63:0]);
    chk("spur_line", bus.d_pmem_rdata, L5);
    bus.mem_resp = 1'b0;
    bus.i_pmem_address = 32'h0000_081F;
    bus.i_pmem_read    = 1'b1;
    tick();
    beats("spur_i", 1, 0, 32'h0000_0800, L7, '0, 1'b0);
    chk("spur_iresp", bus.i_pmem_resp, 256'd1);
    chk("spur_data", bus.i_pmem_rdata, L7);
    bus.i_pmem_read = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
